ped_request_conditioner: RTL

PED_REQUEST_CONDITIONER -- requirements
Module: ped_request_conditioner

---
 rtl/ped_request_conditioner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ped_request_conditioner.sv
// Conditions two asynchronous curbside buttons into a single one-cycle pedestrian request
// for the traffic light controller, with debounce, post-WALK lockout and stuck detection.
module ped_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned STUCK_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       walk_active,
  output logic       pedestrian_request,
  output logic       req_pending,
  output logic       stuck_a,
  output logic       stuck_b,
  output logic [1:0] fsm_state
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned LkW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned StW = $clog2(STUCK_CYCLES + 1);

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LkW-1:0] LkLast = LkW'(LOCKOUT_CYCLES - 1);
  localparam logic [StW-1:0] StMax  = StW'(STUCK_CYCLES);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StIssue    = 2'b01,
    StWaitWalk = 2'b10,
    StLockout  = 2'b11
  } state_e;

  // Index 0 is button A, index 1 is button B.
  logic [1:0]          btn_raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          deb_q, deb_d, deb_dly_q;
  logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0][StW-1:0] st_cnt_q, st_cnt_d;
  logic [1:0]          stuck;
  logic [1:0]          rise;
  logic                press_evt;

  state_e              state_q, state_d;
  logic [LkW-1:0]      lock_cnt_q, lock_cnt_d;
  logic                deferred_q, deferred_d;
  logic                walk_seen_q, walk_seen_d;

  assign btn_raw = {btn_b, btn_a};

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    st_cnt_d = '0;
    stuck    = '0;
    rise     = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
      if (deb_q[i]) begin
        st_cnt_d[i] = (st_cnt_q[i] == StMax) ? st_cnt_q[i] : st_cnt_q[i] + StW'(1);
      end
      // Gated by the debounced level so the flag drops the moment the button releases.
      stuck[i] = deb_q[i] && (st_cnt_q[i] == StMax);
      rise[i]  = deb_q[i] && !deb_dly_q[i] && !stuck[i];
    end
  end

  assign press_evt = |rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      db_cnt_q  <= '0;
      st_cnt_q  <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      db_cnt_q  <= db_cnt_d;
      st_cnt_q  <= st_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      lock_cnt_q  <= '0;
      deferred_q  <= 1'b0;
      walk_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      deferred_q  <= deferred_d;
      walk_seen_q <= walk_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    deferred_d  = deferred_q;
    walk_seen_d = walk_seen_q;
    case (state_q)
      StIdle: begin
        if (press_evt) state_d = StIssue;
      end
      StIssue: begin
        state_d     = StWaitWalk;
        walk_seen_d = 1'b0;
      end
      StWaitWalk: begin
        // WALK must be observed starting and then ending before lockout begins.
        if (walk_active) begin
          walk_seen_d = 1'b1;
        end else if (walk_seen_q) begin
          state_d     = StLockout;
          lock_cnt_d  = '0;
          deferred_d  = 1'b0;
          walk_seen_d = 1'b0;
        end
      end
      StLockout: begin
        if (lock_cnt_q == LkLast) begin
          state_d    = (deferred_q || press_evt) ? StIssue : StIdle;
          deferred_d = 1'b0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LkW'(1);
          if (press_evt) deferred_d = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        lock_cnt_d  = '0;
        deferred_d  = 1'b0;
        walk_seen_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    pedestrian_request = 1'b0;
    req_pending        = 1'b0;
    case (state_q)
      StIssue: begin
        pedestrian_request = 1'b1;
        req_pending        = 1'b1;
      end
      StWaitWalk: req_pending = !walk_seen_q;
      default: ;
    endcase
  end

  assign fsm_state = state_q;
  assign stuck_a   = stuck[0];
  assign stuck_b   = stuck[1];

endmodule
